// File: rtl/xor_map_sequencer_pkg.sv
// Shared sizing, state/direction enums and the command bundle for the xorMap sequencer.
package XorMapSeq_pkg;
  localparam int XMS_EV_WORDS = 64;
  localparam int XMS_ADDR_W   = $clog2(XMS_EV_WORDS);
  localparam int XMS_LEN_W    = XMS_ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} xms_state_e;
  typedef enum logic {ASC, DESC} xms_dir_e;

  typedef struct packed {
    logic [XMS_ADDR_W-1:0] origin;
    logic [XMS_ADDR_W-1:0] modifier;
    logic [XMS_LEN_W-1:0]  length;
    logic                  cond_pass;
  } xor_map_cmd_t;

  // Walking toward the modifier side means a destination word is never re-read after it is written.
  function automatic xms_dir_e walk_dir(input logic [XMS_ADDR_W-1:0] origin,
                                        input logic [XMS_ADDR_W-1:0] modifier);
    return (modifier >= origin) ? ASC : DESC;
  endfunction
endpackage

// File: rtl/xor_map_addr_gen.sv
// Per-word address walker: one index per step, read addresses now, write address one step later.
module xor_map_addr_gen
  import XorMapSeq_pkg::*;
#(
  parameter int ADDR_W = XMS_ADDR_W,
  parameter int LEN_W  = XMS_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] origin,
  input  logic [ADDR_W-1:0] modifier,
  input  logic [LEN_W-1:0]  length,
  input  xms_dir_e          dir,
  output logic [ADDR_W-1:0] rd_a_addr,
  output logic [ADDR_W-1:0] rd_b_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last
);
  logic [ADDR_W-1:0] a_q, a_d, b_q, b_d, w_q, w_d, len_m1;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  xms_dir_e          dir_q, dir_d;

  always_comb begin
    len_m1 = ADDR_W'(length - LEN_W'(1));
    a_d    = a_q;
    b_d    = b_q;
    w_d    = w_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    if (load) begin
      dir_d = dir;
      cnt_d = length;
      if (dir == ASC) begin
        a_d = origin;
        b_d = modifier;
      end else begin
        a_d = origin + len_m1;
        b_d = modifier + len_m1;
      end
    end else if (step) begin
      w_d   = a_q;
      cnt_d = cnt_q - LEN_W'(1);
      if (dir_q == ASC) begin
        a_d = a_q + ADDR_W'(1);
        b_d = b_q + ADDR_W'(1);
      end else begin
        a_d = a_q - ADDR_W'(1);
        b_d = b_q - ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
      dir_q <= ASC;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  assign rd_a_addr = a_q;
  assign rd_b_addr = b_q;
  assign wr_addr   = w_q;
  assign last      = (cnt_q == LEN_W'(1));
endmodule

// File: rtl/xor_map_sequencer.sv
// xorMap engine: mem[origin+i] ^= mem[modifier+i], one word per cycle over a 2R/1W store port.
module xor_map_sequencer
  import XorMapSeq_pkg::*;
#(
  parameter int EV_WORDS = XMS_EV_WORDS,
  parameter int ADDR_W   = $clog2(EV_WORDS),
  parameter int LEN_W    = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_origin,
  input  logic [ADDR_W-1:0] cmd_modifier,
  input  logic [LEN_W-1:0]  cmd_length,
  input  logic              cmd_cond_pass,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_a_addr,
  output logic [ADDR_W-1:0] rd_b_addr,
  input  logic [31:0]       rd_a_data,
  input  logic [31:0]       rd_b_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err_range,
  output logic [LEN_W-1:0]  words_written
);
  xms_state_e       state_q, state_d;
  xor_map_cmd_t     cmd_in;
  logic [LEN_W:0]   end_a, end_b;
  logic             range_err, skip, accept, step, last;
  logic             rd_en_d, rd_en_q, wr_en_d, wr_en_q, done_d, done_q;
  logic             err_d, err_q, busy_d, busy_q, ready_d, ready_q;
  logic [LEN_W-1:0] ww_d, ww_q;

  assign cmd_in = '{origin: cmd_origin, modifier: cmd_modifier,
                    length: cmd_length, cond_pass: cmd_cond_pass};

  // One extra bit on the end sums so origin+len cannot wrap past the store.
  assign end_a     = (LEN_W+1)'(cmd_in.origin) + (LEN_W+1)'(cmd_in.length);
  assign end_b     = (LEN_W+1)'(cmd_in.modifier) + (LEN_W+1)'(cmd_in.length);
  assign range_err = (end_a > (LEN_W+1)'(EV_WORDS)) || (end_b > (LEN_W+1)'(EV_WORDS));
  assign skip      = (cmd_in.length == '0) || !cmd_in.cond_pass || range_err;
  assign accept    = (state_q == IDLE) && cmd_valid;
  assign step      = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    ww_d    = ww_q + LEN_W'(wr_en_q);
    case (state_q)
      IDLE: if (cmd_valid) begin
        ww_d = '0;
        if (skip) begin
          state_d = DONE;
          // A failed condition suppresses the instruction entirely, range error included.
          err_d   = cmd_in.cond_pass && range_err;
        end else begin
          state_d = RUN;
        end
      end
      RUN:     if (last) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rd_en_d = (state_d == RUN);
    wr_en_d = (state_q == RUN);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      ww_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      ww_q    <= ww_d;
    end
  end

  xor_map_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .step      (step),
    .origin    (cmd_in.origin),
    .modifier  (cmd_in.modifier),
    .length    (cmd_in.length),
    .dir       (walk_dir(cmd_in.origin, cmd_in.modifier)),
    .rd_a_addr (rd_a_addr),
    .rd_b_addr (rd_b_addr),
    .wr_addr   (wr_addr),
    .last      (last)
  );

  assign cmd_ready     = ready_q;
  assign rd_en         = rd_en_q;
  assign wr_en         = wr_en_q;
  assign wr_data       = rd_a_data ^ rd_b_data;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_range     = err_q;
  assign words_written = ww_q;
endmodule

// File: tb/tb_xor_map_sequencer.sv
// Directed bench for xor_map_sequencer with a whole-state reference model checked every cycle.
module tb_xor_map_sequencer;
  localparam int EVW = 64;
  localparam int AW  = 6;
  localparam int LW  = 7;

  logic          clk = 1'b0;
  logic          reset, cmd_valid, cmd_ready, cmd_cond_pass;
  logic [AW-1:0] cmd_origin, cmd_modifier, rd_a_addr, rd_b_addr, wr_addr;
  logic [LW-1:0] cmd_length, words_written;
  logic          rd_en, wr_en, busy, done, err_range;
  logic [31:0]   rd_a_data, rd_b_data, wr_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xor_map_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_origin(cmd_origin), .cmd_modifier(cmd_modifier), .cmd_length(cmd_length),
    .cmd_cond_pass(cmd_cond_pass), .rd_en(rd_en), .rd_a_addr(rd_a_addr),
    .rd_b_addr(rd_b_addr), .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .err_range(err_range), .words_written(words_written)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word store: read-before-write, data one cycle after rd_en.
  logic [31:0] mem [EVW];
  logic [31:0] pat [EVW];
  logic        load_mem = 1'b0;
  always @(posedge clk) begin
    if (load_mem) for (int k = 0; k < EVW; k++) mem[k] <= pat[k];
    else if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) begin
      rd_a_data <= mem[rd_a_addr];
      rd_b_data <= mem[rd_b_addr];
    end
  end

  // Reference: timeline relative to the accept edge, data from a snapshot of the store.
  logic        m_ok = 1'b0, m_busy = 1'b0, m_short = 1'b0, m_err = 1'b0, m_asc = 1'b1;
  int          m_t = 0, m_len = 0, m_org = 0, m_mod = 0, m_ww = 0, m_done_t;
  logic [31:0] snap [EVW];

  function automatic bit rng_bad(input int o, input int m, input int l);
    return (o + l > EVW) || (m + l > EVW);
  endfunction
  function automatic int idx(input int i);
    return m_asc ? i : m_len - 1 - i;
  endfunction
  function automatic bit e_rd();
    return m_busy && !m_short && m_t <= m_len;
  endfunction
  function automatic bit e_wr();
    return m_busy && !m_short && m_t >= 2 && m_t <= m_len + 1;
  endfunction
  function automatic bit e_done();
    return m_busy && m_t == m_done_t;
  endfunction

  always_comb m_done_t = m_short ? 1 : m_len + 2;

  always @(posedge clk) begin
    if (reset) begin
      m_ok   <= 1'b1;
      m_busy <= 1'b0;
      m_ww   <= 0;
    end else if (m_ok && !m_busy) begin
      if (cmd_valid) begin
        m_org   <= int'(cmd_origin);
        m_mod   <= int'(cmd_modifier);
        m_len   <= int'(cmd_length);
        m_err   <= cmd_cond_pass && rng_bad(int'(cmd_origin), int'(cmd_modifier), int'(cmd_length));
        m_short <= cmd_length == 0 || !cmd_cond_pass ||
                   rng_bad(int'(cmd_origin), int'(cmd_modifier), int'(cmd_length));
        m_asc   <= cmd_modifier >= cmd_origin;
        for (int k = 0; k < EVW; k++) snap[k] <= mem[k];
        m_busy  <= 1'b1;
        m_t     <= 1;
        m_ww    <= 0;
      end
    end else if (m_ok) begin
      if (m_t == m_done_t) m_busy <= 1'b0;
      else begin
        m_t  <= m_t + 1;
        m_ww <= m_short ? 0 : m_t - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("rd_en", 32'(rd_en), 32'(e_rd()));
      chk("wr_en", 32'(wr_en), 32'(e_wr()));
      chk("done", 32'(done), 32'(e_done()));
      chk("err_range", 32'(err_range), 32'(e_done() && m_err));
      chk("words_written", 32'(words_written), 32'(m_ww));
      if (e_rd()) begin
        chk("rd_a_addr", 32'(rd_a_addr), 32'((m_org + idx(m_t - 1)) % EVW));
        chk("rd_b_addr", 32'(rd_b_addr), 32'((m_mod + idx(m_t - 1)) % EVW));
      end
      if (e_wr()) begin
        chk("wr_addr", 32'(wr_addr), 32'((m_org + idx(m_t - 2)) % EVW));
        chk("wr_data", wr_data,
            snap[(m_org + idx(m_t - 2)) % EVW] ^ snap[(m_mod + idx(m_t - 2)) % EVW]);
      end
    end
  end

  int   r_done, r_first, r_last, r_nwr;
  logic r_err;
  logic [LW-1:0] r_ww;

  task automatic load_pat(input int kind);
    for (int k = 0; k < EVW; k++) begin
      case (kind)
        1:       pat[k] = (k >= 16 && k < 20) ? 32'hFFFF0000 + 32'(k - 16) : 32'(k);
        2:       pat[k] = (k < 32) ? (32'd1 << k) : 32'd0;
        default: pat[k] = 32'(k);
      endcase
    end
    load_mem = 1'b1;
    @(posedge clk); #1 load_mem = 1'b0;
  endtask

  // Counts cycles after the accept edge; cycle c is sampled at its negedge.
  task automatic wait_done();
    r_done = -1; r_first = -1; r_last = -1; r_nwr = 0; r_err = 1'b0; r_ww = '0;
    for (int c = 1; c <= 100 && r_done < 0; c++) begin
      @(negedge clk);
      if (wr_en) begin
        if (r_first < 0) r_first = c;
        r_last = c;
        r_nwr++;
      end
      if (done) begin
        r_done = c;
        r_err  = err_range;
        r_ww   = words_written;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic set_cmd(input int o, input int m, input int l, input bit cp);
    cmd_origin = AW'(o); cmd_modifier = AW'(m); cmd_length = LW'(l);
    cmd_cond_pass = cp; cmd_valid = 1'b1;
  endtask

  task automatic run_cmd(input int o, input int m, input int l, input bit cp);
    int n;
    set_cmd(o, m, l, cp);
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_origin = '0; cmd_modifier = '0;
    cmd_length = '0; cmd_cond_pass = 1'b0;
    load_pat(0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst rd_en", 32'(rd_en), 32'd0);
    chk("rst wr_en", 32'(wr_en), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err_range", 32'(err_range), 32'd0);
    chk("rst words_written", 32'(words_written), 32'd0);
    chk("rst rd_a_addr", 32'(rd_a_addr), 32'd0);
    chk("rst rd_b_addr", 32'(rd_b_addr), 32'd0);
    chk("rst wr_addr", 32'(wr_addr), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle rd_en", 32'(rd_en), 32'd0);
      chk("idle wr_en", 32'(wr_en), 32'd0);
      chk("idle cmd_ready", 32'(cmd_ready), 32'd1);
    end
    @(posedge clk); #1;

    // Basic ascending run with cycle-exact timing.
    load_pat(1);
    run_cmd(0, 16, 4, 1'b1);
    chk("t2 done cycle", 32'(r_done), 32'd6);
    chk("t2 first write", 32'(r_first), 32'd2);
    chk("t2 last write", 32'(r_last), 32'd5);
    chk("t2 write count", 32'(r_nwr), 32'd4);
    chk("t2 words_written", 32'(r_ww), 32'd4);
    chk("t2 err", 32'(r_err), 32'd0);
    for (int i = 0; i < 4; i++) chk("t2 mem", mem[i], 32'hFFFF0000);
    chk("t2 mem4 untouched", mem[4], 32'd4);

    // Overlap, descending walk.
    load_pat(0);
    run_cmd(4, 2, 4, 1'b1);
    chk("t3 mem4", mem[4], 32'd6);
    chk("t3 mem5", mem[5], 32'd6);
    chk("t3 mem6", mem[6], 32'd2);
    chk("t3 mem7", mem[7], 32'd2);
    chk("t3 done cycle", 32'(r_done), 32'd6);

    // Overlap, ascending walk.
    load_pat(2);
    run_cmd(2, 3, 3, 1'b1);
    chk("t4 mem2", mem[2], 32'hC);
    chk("t4 mem3", mem[3], 32'h18);
    chk("t4 mem4", mem[4], 32'h30);
    chk("t4 mem5", mem[5], 32'h20);
    chk("t4 done cycle", 32'(r_done), 32'd5);
    chk("t4 words_written", 32'(r_ww), 32'd3);

    // Short-circuit commands.
    run_cmd(0, 8, 0, 1'b1);
    chk("t5 len0 done", 32'(r_done), 32'd1);
    chk("t5 len0 err", 32'(r_err), 32'd0);
    chk("t5 len0 ww", 32'(r_ww), 32'd0);
    chk("t5 len0 writes", 32'(r_nwr), 32'd0);
    run_cmd(0, 8, 5, 1'b0);
    chk("t5 nocond done", 32'(r_done), 32'd1);
    chk("t5 nocond err", 32'(r_err), 32'd0);
    chk("t5 nocond ww", 32'(r_ww), 32'd0);
    chk("t5 nocond writes", 32'(r_nwr), 32'd0);
    run_cmd(60, 0, 8, 1'b1);
    chk("t5 range done", 32'(r_done), 32'd1);
    chk("t5 range err", 32'(r_err), 32'd1);
    chk("t5 range writes", 32'(r_nwr), 32'd0);

    // Boundaries: range ending exactly at the top, and a full-store self-xor.
    load_pat(0);
    run_cmd(60, 0, 4, 1'b1);
    chk("edge done cycle", 32'(r_done), 32'd6);
    chk("edge err", 32'(r_err), 32'd0);
    chk("edge mem60", mem[60], 32'd60);
    chk("edge mem63", mem[63], 32'd60);
    run_cmd(0, 0, 64, 1'b1);
    chk("full done cycle", 32'(r_done), 32'd66);
    chk("full words_written", 32'(r_ww), 32'd64);
    chk("full mem0", mem[0], 32'd0);
    chk("full mem63", mem[63], 32'd0);

    // Reset during a run, then an immediate new command.
    load_pat(0);
    set_cmd(8, 32, 8, 1'b1);
    @(negedge clk);
    chk("t6 ready before", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    set_cmd(40, 48, 4, 1'b1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t6 wr_en after reset", 32'(wr_en), 32'd0);
    chk("t6 done after reset", 32'(done), 32'd0);
    chk("t6 ready after reset", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_done();
    chk("t6 done cycle", 32'(r_done), 32'd6);
    chk("t6 words_written", 32'(r_ww), 32'd4);
    for (int i = 0; i < 4; i++) chk("t6 mem new", mem[40 + i], 32'd24);
    chk("t6 mem8", mem[8], 32'd40);
    chk("t6 mem9", mem[9], 32'd40);
    chk("t6 mem10 not written", mem[10], 32'd10);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end
endmodule
